// File: rtl/sap1_pkg.sv
// Shared opcodes, one-hot T-state encoding and control-word layout for the SAP-1 sequencer.
package sap1_pkg;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  // HALT is the all-zero ring: no T-state bit is live.
  typedef enum logic [5:0] {
    S_HALT = 6'b000000,
    S_T1   = 6'b000001,
    S_T2   = 6'b000010,
    S_T3   = 6'b000100,
    S_T4   = 6'b001000,
    S_T5   = 6'b010000,
    S_T6   = 6'b100000
  } state_e;

  typedef struct packed {
    logic pc_increment;
    logic pc_enable;
    logic mar_load;
    logic ram_enable;
    logic ir_load;
    logic ir_enable;
    logic a_load;
    logic a_enable;
    logic b_load;
    logic alu_enable;
    logic alu_subtract;
    logic out_load;
  } ctrl_t;

  // Instructions that fetch an operand from RAM and so need the full cycle.
  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/sap1_ring_counter.sv
// One-hot T-state ring: advances T1..T6, reloads to T1 on restart, parks in HALT on halt_req.
module sap1_ring_counter
  import sap1_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   restart,
  input  logic   halt_req,
  output state_e state
);

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_T1;
    end else if (halt_req) begin
      state <= S_HALT;
    end else if (restart) begin
      state <= S_T1;
    end else begin
      case (state)
        S_T1:    state <= S_T2;
        S_T2:    state <= S_T3;
        S_T3:    state <= S_T4;
        S_T4:    state <= S_T5;
        S_T5:    state <= S_T6;
        S_T6:    state <= S_T1;
        S_HALT:  state <= S_HALT;
        default: state <= S_T1;
      endcase
    end
  end

endmodule

// File: rtl/controller_sequencer.sv
// SAP-1 control sequencer: decodes T-state and opcode into the W-bus control lines.
// Optional VAR_CYCLE_EN: short instructions return to T1 early instead of idling to T6.
module controller_sequencer
  import sap1_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] opcode,
  output logic [5:0] t_state,
  output logic       pc_increment,
  output logic       pc_enable,
  output logic       mar_load,
  output logic       ram_enable,
  output logic       ir_load,
  output logic       ir_enable,
  output logic       a_load,
  output logic       a_enable,
  output logic       b_load,
  output logic       alu_enable,
  output logic       alu_subtract,
  output logic       out_load,
  output logic       halt
);

  state_e state;
  ctrl_t  ctrl;
  logic   restart;
  logic   halt_req;

  sap1_ring_counter u_ring (
    .clk      (clk),
    .reset    (reset),
    .restart  (restart),
    .halt_req (halt_req),
    .state    (state)
  );

  assign halt_req = (state == S_T4) && (opcode == OP_HLT);

`ifdef VAR_CYCLE_EN
  assign restart = ((state == S_T5) && (opcode == OP_LDA)) ||
                   ((state == S_T4) && !is_mem_op(opcode) && (opcode != OP_HLT));
`else
  assign restart = 1'b0;
`endif

  always_comb begin
    // NOTE: default every control low first so no decode path can infer a latch.
    ctrl = '0;
    if (!reset) begin
      case (state)
        S_T1: begin
          ctrl.pc_enable = 1'b1;
          ctrl.mar_load  = 1'b1;
        end
        S_T2: ctrl.pc_increment = 1'b1;
        S_T3: begin
          ctrl.ram_enable = 1'b1;
          ctrl.ir_load    = 1'b1;
        end
        S_T4: begin
          if (is_mem_op(opcode)) begin
            ctrl.ir_enable = 1'b1;
            ctrl.mar_load  = 1'b1;
          end else if (opcode == OP_OUT) begin
            ctrl.a_enable = 1'b1;
            ctrl.out_load = 1'b1;
          end
        end
        S_T5: begin
          if (opcode == OP_LDA) begin
            ctrl.ram_enable = 1'b1;
            ctrl.a_load     = 1'b1;
          end else if ((opcode == OP_ADD) || (opcode == OP_SUB)) begin
            ctrl.ram_enable   = 1'b1;
            ctrl.b_load       = 1'b1;
            ctrl.alu_subtract = (opcode == OP_SUB);
          end
        end
        S_T6: begin
          if ((opcode == OP_ADD) || (opcode == OP_SUB)) begin
            ctrl.alu_enable   = 1'b1;
            ctrl.a_load       = 1'b1;
            ctrl.alu_subtract = (opcode == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

  // The ring reloads synchronously, so reset is also applied to the visible outputs directly.
  assign t_state = reset ? S_T1 : state;
  assign halt    = !reset && (state == S_HALT);

  assign pc_increment = ctrl.pc_increment;
  assign pc_enable    = ctrl.pc_enable;
  assign mar_load     = ctrl.mar_load;
  assign ram_enable   = ctrl.ram_enable;
  assign ir_load      = ctrl.ir_load;
  assign ir_enable    = ctrl.ir_enable;
  assign a_load       = ctrl.a_load;
  assign a_enable     = ctrl.a_enable;
  assign b_load       = ctrl.b_load;
  assign alu_enable   = ctrl.alu_enable;
  assign alu_subtract = ctrl.alu_subtract;
  assign out_load     = ctrl.out_load;

endmodule

// File: tb/tb_controller_sequencer.sv
// Self-checking bench for controller_sequencer: directed sequences plus random opcode/reset
// traffic, compared every cycle against an instruction-level model.
module tb_controller_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] opcode = 4'h0;
  logic [5:0] t_state;
  logic pc_increment, pc_enable, mar_load, ram_enable, ir_load, ir_enable;
  logic a_load, a_enable, b_load, alu_enable, alu_subtract, out_load, halt;

  controller_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .opcode       (opcode),
    .t_state      (t_state),
    .pc_increment (pc_increment),
    .pc_enable    (pc_enable),
    .mar_load     (mar_load),
    .ram_enable   (ram_enable),
    .ir_load      (ir_load),
    .ir_enable    (ir_enable),
    .a_load       (a_load),
    .a_enable     (a_enable),
    .b_load       (b_load),
    .alu_enable   (alu_enable),
    .alu_subtract (alu_subtract),
    .out_load     (out_load),
    .halt         (halt)
  );

  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_err = 0;
  int         m_step = 1;      // model: 1..6 = T-step within instruction, 0 = halted
  logic [5:0] last_t;
  string      phase = "init";

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s/%s: observed %0h expected %0h (t=%0t)", phase, tag, got, exp, $time);
    end
  endtask

  // Cycles per instruction before returning to T1.
  function automatic int instr_len(input logic [3:0] op);
`ifdef VAR_CYCLE_EN
    if (op == 4'b0000) return 5;
    if (op == 4'b0001 || op == 4'b0010) return 6;
    return 4;
`else
    return 6;
`endif
  endfunction

  // Expected control word, order {pc_inc,pc_en,mar,ram,ir_ld,ir_en,a_ld,a_en,b_ld,alu,sub,out}.
  function automatic logic [11:0] exp_ctrl(input int step, input logic [3:0] op);
    logic pci, pce, mar, ram, irl, ire, al, ae, bl, alu, sub, outl;
    logic arith;
    {pci, pce, mar, ram, irl, ire, al, ae, bl, alu, sub, outl} = '0;
    arith = (op == 4'b0001) || (op == 4'b0010);
    case (step)
      1: begin pce = 1; mar = 1; end
      2: pci = 1;
      3: begin ram = 1; irl = 1; end
      4: if (op == 4'b0000 || arith) begin ire = 1; mar = 1; end
         else if (op == 4'b1110) begin ae = 1; outl = 1; end
      5: if (op == 4'b0000) begin ram = 1; al = 1; end
         else if (arith) begin ram = 1; bl = 1; sub = (op == 4'b0010); end
      6: if (arith) begin alu = 1; al = 1; sub = (op == 4'b0010); end
      default: ;
    endcase
    return {pci, pce, mar, ram, irl, ire, al, ae, bl, alu, sub, outl};
  endfunction

  // One clock: drive inputs at negedge, check outputs, advance the model at posedge.
  task automatic cyc(input logic r, input logic [3:0] op);
    logic [5:0]  exp_t;
    logic [11:0] exp_c;
    logic        exp_h;
    int          nxt;
    @(negedge clk);
    reset  = r;
    opcode = op;
    #1;
    if (r) begin
      exp_t = 6'b000001; exp_c = '0; exp_h = 1'b0;
    end else begin
      exp_t = (m_step == 0) ? 6'b0 : 6'(1 << (m_step - 1));
      exp_c = exp_ctrl(m_step, op);
      exp_h = (m_step == 0);
    end
    last_t = t_state;
    check("t_state", 32'(t_state), 32'(exp_t));
    check("ctrl", 32'({pc_increment, pc_enable, mar_load, ram_enable, ir_load, ir_enable,
                       a_load, a_enable, b_load, alu_enable, alu_subtract, out_load}),
          32'(exp_c));
    check("halt", 32'(halt), 32'(exp_h));
    check("bus_excl", 32'($countones({pc_enable, ram_enable, ir_enable, a_enable, alu_enable}) <= 1),
          32'd1);
    if (r)                               nxt = 1;
    else if (m_step == 0)                nxt = 0;
    else if (m_step == 4 && op == 4'hF)  nxt = 0;
    else if (m_step >= instr_len(op))    nxt = 1;
    else                                 nxt = m_step + 1;
    @(posedge clk);
    m_step = nxt;
  endtask

  // Observed instruction length: cycles from one T1 to the next.
  task automatic measure_len(input logic [3:0] op);
    int n;
    cyc(1'b1, op);
    cyc(1'b0, op);
    n = 0;
    do begin
      cyc(1'b0, op);
      n++;
    end while (last_t != 6'b000001 && n < 10);
    check($sformatf("len_op%0h", op), 32'(n), 32'(instr_len(op)));
  endtask

  initial begin
    logic [3:0] cur_op;
    int         halt_cnt;
    logic       r;
    logic [3:0] op;

    phase = "fetch";
    cyc(1'b1, 4'h0);
    for (int i = 0; i < 6; i++) cyc(1'b0, 4'h5);

    phase = "add";
    cyc(1'b1, 4'h1);
    for (int i = 0; i < 6; i++) cyc(1'b0, 4'h1);
    phase = "sub";
    cyc(1'b1, 4'h2);
    for (int i = 0; i < 6; i++) cyc(1'b0, 4'h2);

    phase = "hlt";
    cyc(1'b1, 4'hF);
    for (int i = 0; i < 4; i++) cyc(1'b0, 4'hF);
    for (int i = 0; i < 20; i++) cyc(1'b0, 4'($urandom_range(0, 15)));
    cyc(1'b1, 4'h0);
    cyc(1'b0, 4'h0);

    phase = "rst_mid_lda";
    cyc(1'b1, 4'h0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 4'h0);
    cyc(1'b1, 4'h0);
    cyc(1'b0, 4'h0);

    phase = "length";
    measure_len(4'hE);
    measure_len(4'h0);
    measure_len(4'h1);
    measure_len(4'h5);

    phase = "all_ops";
    for (int o = 0; o < 16; o++) begin
      cyc(1'b1, 4'(o));
      for (int i = 0; i < 7; i++) cyc(1'b0, 4'(o));
    end

    phase = "random";
    cyc(1'b1, 4'h0);
    cur_op   = 4'h0;
    halt_cnt = 0;
    for (int i = 0; i < 1500; i++) begin
      if (m_step == 0) begin
        halt_cnt++;
        r = (halt_cnt > 4);
        if (r) halt_cnt = 0;
      end else begin
        r = ($urandom_range(0, 59) == 0);
      end
      if (m_step == 4) begin
        cur_op = 4'($urandom_range(0, 15));
        if (cur_op == 4'hF && $urandom_range(0, 3) != 0) cur_op = 4'($urandom_range(0, 14));
      end
      op = (m_step >= 4) ? cur_op : 4'($urandom_range(0, 15));
      cyc(r, op);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
